// File: rtl/alu_ctrl.sv
// Two-requester sequencer in front of a shared combinational 32-bit ALU; shifts iterate one bit per cycle.
// Define ALU_CTRL_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_ctrl #(
   parameter int WIDTH = 32,
   parameter int NREQ  = 2
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_req0,
   input  logic             i_req1,
   input  logic [4:0]       i_op0,
   input  logic [4:0]       i_op1,
   input  logic [WIDTH-1:0] i_a0,
   input  logic [WIDTH-1:0] i_a1,
   input  logic [WIDTH-1:0] i_b0,
   input  logic [WIDTH-1:0] i_b1,
   output logic             o_ack0,
   output logic             o_ack1,
   output logic [4:0]       o_alu_op,
   output logic [WIDTH-1:0] o_alu_a,
   output logic [WIDTH-1:0] o_alu_b,
   input  logic [WIDTH-1:0] i_alu_out,
   output logic [WIDTH-1:0] o_result,
   output logic [7:0]       o_flags,
   output logic             o_valid,
   output logic             o_owner
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_EXEC  = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [4:0] OP_LSR = 5'd5;
   localparam logic [4:0] OP_LSL = 5'd6;
   localparam logic [4:0] OP_ASR = 5'd7;

   logic [1:0]       state;
   logic [4:0]       op;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] work;
   logic [4:0]       cnt;
   logic             carry;
   logic             ill;
   logic             owner_cur;
   logic [NREQ-1:0]  ack;

   logic             any_req;
   logic             grant_sel;
   logic [4:0]       sel_op;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic             sel_shift;

   assign any_req = i_req0 | i_req1;

`ifdef ALU_CTRL_RR_EN
   logic last;
   // On contention the requester not granted last wins.
   assign grant_sel = i_req1 & (~i_req0 | ~last);
`else
   assign grant_sel = i_req1 & ~i_req0;
`endif

   assign sel_op    = grant_sel ? i_op1 : i_op0;
   assign sel_a     = grant_sel ? i_a1  : i_a0;
   assign sel_b     = grant_sel ? i_b1  : i_b0;
   assign sel_shift = (sel_op >= OP_LSR) && (sel_op <= OP_ASR);

   assign o_ack0  = ack[0];
   assign o_ack1  = ack[1];
   assign o_valid = (state == S_DONE);

   function automatic logic [7:0] make_flags(input logic [WIDTH-1:0] r, input logic c,
                                             input logic il);
      return {il, 4'b0000, c, r[WIDTH-1], (r == '0)};
   endfunction

   always_comb begin
      o_alu_op = '0;
      o_alu_a  = '0;
      o_alu_b  = '0;
      if (state == S_EXEC && !ill) begin
         o_alu_op = op;
         o_alu_a  = opa;
         o_alu_b  = opb;
      end else if (state == S_SHIFT && cnt != 5'd0) begin
         o_alu_op = (op == OP_LSL) ? OP_LSL : OP_LSR;
         o_alu_a  = work;
         o_alu_b  = {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state     <= S_IDLE;
         op        <= '0;
         opa       <= '0;
         opb       <= '0;
         work      <= '0;
         cnt       <= '0;
         carry     <= 1'b0;
         ill       <= 1'b0;
         owner_cur <= 1'b0;
         ack       <= '0;
         o_result  <= '0;
         o_flags   <= '0;
         o_owner   <= 1'b0;
`ifdef ALU_CTRL_RR_EN
         last      <= 1'b1;
`endif
      end else begin
         ack <= '0;
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  op             <= sel_op;
                  opa            <= sel_a;
                  opb            <= sel_b;
                  work           <= sel_a;
                  cnt            <= sel_b[4:0];
                  carry          <= 1'b0;
                  ill            <= (sel_op > OP_ASR);
                  owner_cur      <= grant_sel;
                  ack[grant_sel] <= 1'b1;
`ifdef ALU_CTRL_RR_EN
                  last           <= grant_sel;
`endif
                  // Illegal ops use the EXEC slot with the ALU idle, so valid follows the ack cycle.
                  state          <= sel_shift ? S_SHIFT : S_EXEC;
               end
            end
            S_EXEC: begin
               o_result <= ill ? '0 : i_alu_out;
               o_flags  <= make_flags(ill ? '0 : i_alu_out, 1'b0, ill);
               o_owner  <= owner_cur;
               state    <= S_DONE;
            end
            S_SHIFT: begin
               if (cnt == 5'd0) begin
                  o_result <= work;
                  o_flags  <= make_flags(work, carry, 1'b0);
                  o_owner  <= owner_cur;
                  state    <= S_DONE;
               end else begin
                  if (op == OP_ASR)
                     work <= {opa[WIDTH-1], i_alu_out[WIDTH-2:0]};
                  else
                     work <= i_alu_out;
                  carry <= (op == OP_LSL) ? work[WIDTH-1] : work[0];
                  cnt   <= cnt - 5'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: per-cycle comparison against a transaction-level model
// plus directed vectors with literal expectations. Arbitration expectations follow ALU_CTRL_RR_EN.
module tb_alu_ctrl;

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_req0 = 1'b0, i_req1 = 1'b0;
   logic [4:0]  i_op0 = '0, i_op1 = '0;
   logic [31:0] i_a0 = '0, i_a1 = '0, i_b0 = '0, i_b1 = '0;
   logic        o_ack0, o_ack1, o_valid, o_owner;
   logic [4:0]  o_alu_op;
   logic [31:0] o_alu_a, o_alu_b, i_alu_out, o_result;
   logic [7:0]  o_flags;

   int n_total = 0;
   int n_pass  = 0;
   int edge_cnt = 0;
   logic cmp_en = 1'b0;

   alu_ctrl #(.WIDTH(32), .NREQ(2)) dut (
      .i_clk(clk), .i_reset(i_reset),
      .i_req0(i_req0), .i_req1(i_req1), .i_op0(i_op0), .i_op1(i_op1),
      .i_a0(i_a0), .i_a1(i_a1), .i_b0(i_b0), .i_b1(i_b1),
      .o_ack0(o_ack0), .o_ack1(o_ack1),
      .o_alu_op(o_alu_op), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .i_alu_out(i_alu_out),
      .o_result(o_result), .o_flags(o_flags), .o_valid(o_valid), .o_owner(o_owner)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // The shared ALU the controller drives.
   always_comb begin
      case (o_alu_op)
         5'd0: i_alu_out = o_alu_a - o_alu_b;
         5'd1: i_alu_out = o_alu_a & o_alu_b;
         5'd2: i_alu_out = o_alu_a + o_alu_b;
         5'd3: i_alu_out = o_alu_a | o_alu_b;
         5'd4: i_alu_out = o_alu_a ^ o_alu_b;
         5'd5: i_alu_out = o_alu_a >> o_alu_b[4:0];
         5'd6: i_alu_out = o_alu_a << o_alu_b[4:0];
         5'd7: i_alu_out = $unsigned($signed(o_alu_a) >>> o_alu_b[4:0]);
         default: i_alu_out = '0;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   // Whole-operation reference: result, flags and the number of edges from grant to result.
   function automatic void model_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [7:0] f, output int d);
      int k;
      logic c, il;
      k = int'(b[4:0]);
      c = 1'b0;
      il = 1'b0;
      d = 1;
      r = '0;
      case (op)
         5'd0: r = a - b;
         5'd1: r = a & b;
         5'd2: r = a + b;
         5'd3: r = a | b;
         5'd4: r = a ^ b;
         5'd5: begin r = a >> k; if (k > 0) c = a[k-1]; d = k + 1; end
         5'd6: begin r = a << k; if (k > 0) c = a[32-k]; d = k + 1; end
         5'd7: begin r = $unsigned($signed(a) >>> k); if (k > 0) c = a[k-1]; d = k + 1; end
         default: il = 1'b1;
      endcase
      f = {il, 4'b0000, c, r[31], (r == 32'd0)};
   endfunction

   // Transaction-level model: one op in flight, result d edges after grant, one idle edge after valid.
   logic        m_ack0 = 0, m_ack1 = 0, m_valid = 0, m_owner = 0, m_last = 1;
   logic [31:0] m_result = '0, p_result = '0;
   logic [7:0]  m_flags = '0, p_flags = '0;
   logic        p_owner = 0, pend = 0, cool = 0;
   int          pend_left = 0;

   always @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         m_ack0 = 0; m_ack1 = 0; m_valid = 0; m_owner = 0; m_last = 1;
         m_result = '0; m_flags = '0; pend = 0; cool = 0; pend_left = 0;
      end else begin
         m_ack0 = 0; m_ack1 = 0; m_valid = 0;
         if (pend) begin
            if (pend_left == 1) begin
               m_result = p_result; m_flags = p_flags; m_owner = p_owner;
               m_valid = 1; pend = 0; cool = 1;
            end else begin
               pend_left--;
            end
         end else if (cool) begin
            cool = 0;
         end else if (i_req0 || i_req1) begin
            logic w;
`ifdef ALU_CTRL_RR_EN
            w = (i_req0 && i_req1) ? !m_last : i_req1;
`else
            w = !i_req0;
`endif
            m_last = w;
            if (w) model_op(i_op1, i_a1, i_b1, p_result, p_flags, pend_left);
            else   model_op(i_op0, i_a0, i_b0, p_result, p_flags, pend_left);
            p_owner = w;
            pend = 1;
            m_ack0 = !w;
            m_ack1 = w;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("ack0",   {31'd0, o_ack0},  {31'd0, m_ack0});
         check("ack1",   {31'd0, o_ack1},  {31'd0, m_ack1});
         check("valid",  {31'd0, o_valid}, {31'd0, m_valid});
         check("result", o_result, m_result);
         check("flags",  {24'd0, o_flags}, {24'd0, m_flags});
         check("owner",  {31'd0, o_owner}, {31'd0, m_owner});
      end
   end

   task automatic send(input int who, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int gedge);
      logic got;
      got = 0;
      gedge = -1;
      @(negedge clk);
      if (who == 1) begin i_req1 = 1; i_op1 = op; i_a1 = a; i_b1 = b; end
      else          begin i_req0 = 1; i_op0 = op; i_a0 = a; i_b0 = b; end
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if ((who == 1) ? o_ack1 : o_ack0) got = 1;
      end
      i_req0 = 0; i_req1 = 0;
      gedge = edge_cnt;
      if (!got) check("ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_valid(input string name, output int vedge);
      logic got;
      got = 0;
      vedge = -1;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         if (o_valid) got = 1;
      end
      vedge = edge_cnt;
      if (!got) check({name, "_valid_timeout"}, 32'd0, 32'd1);
      else $display("txn %s: owner=%0d result=0x%08h flags=0x%02h", name, o_owner, o_result, o_flags);
   endtask

   task automatic run_op(input string name, input int who, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_r,
                         input logic [7:0] exp_f, input int exp_lat);
      int g, v;
      send(who, op, a, b, g);
      wait_valid(name, v);
      check({name, "_result"}, o_result, exp_r);
      check({name, "_flags"}, {24'd0, o_flags}, {24'd0, exp_f});
      check({name, "_owner"}, {31'd0, o_owner}, who[0] ? 32'd1 : 32'd0);
      check({name, "_latency"}, v - g, exp_lat);
   endtask

   initial begin
      int g, nvalid;
      int grants[$];
      int exp_grants[4];
      repeat (3) @(negedge clk);
      check("rst_result", o_result, 32'd0);
      check("rst_flags",  {24'd0, o_flags}, 32'd0);
      check("rst_valid",  {31'd0, o_valid}, 32'd0);
      check("rst_ack",    {30'd0, o_ack1, o_ack0}, 32'd0);
      check("rst_aluop",  {27'd0, o_alu_op}, 32'd0);
      i_reset = 0;
      cmp_en = 1;

      // Latency counts edges from the grant edge to the edge that opens the valid cycle.
      run_op("add",    0, 5'd2, 32'd5,          32'd7, 32'd12,         8'h00, 1);
      run_op("sub",    1, 5'd0, 32'd3,          32'd3, 32'd0,          8'h01, 1);
      run_op("asr",    0, 5'd7, 32'h8000_0010,  32'd4, 32'hF800_0001,  8'h02, 5);
      run_op("lsl",    0, 5'd6, 32'h8000_0001,  32'd1, 32'h0000_0002,  8'h04, 2);
      run_op("lsr0",   1, 5'd5, 32'h8000_0000,  32'd0, 32'h8000_0000,  8'h02, 1);
      run_op("lsr3",   0, 5'd5, 32'h0000_00F4,  32'd3, 32'h0000_001E,  8'h04, 4);
      run_op("ill",    1, 5'd9, 32'h1234_5678,  32'd1, 32'd0,          8'h81, 1);

      // Abort a long shift with an asynchronous reset.
      send(0, 5'd5, 32'hFFFF_0000, 32'd20, g);
      repeat (5) @(posedge clk);
      #1 i_reset = 1;
      #1;
      check("abort_result", o_result, 32'd0);
      check("abort_flags",  {24'd0, o_flags}, 32'd0);
      check("abort_owner",  {31'd0, o_owner}, 32'd0);
      check("abort_alu_a",  o_alu_a, 32'd0);
      check("abort_alu_op", {27'd0, o_alu_op}, 32'd0);
      @(negedge clk);
      i_reset = 0;
      nvalid = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (o_valid) nvalid++;
      end
      check("abort_no_valid", nvalid, 32'd0);
      run_op("post_rst", 1, 5'd2, 32'd100, 32'd23, 32'd123, 8'h00, 1);

      // Both requesters hold ADDs until four grants have been observed.
      @(negedge clk);
      i_req0 = 1; i_op0 = 5'd2; i_a0 = 32'd1;  i_b0 = 32'd1;
      i_req1 = 1; i_op1 = 5'd2; i_a1 = 32'd10; i_b1 = 32'd10;
      for (int i = 0; i < 40 && grants.size() < 4; i++) begin
         @(negedge clk);
         if (o_ack0) grants.push_back(0);
         if (o_ack1) grants.push_back(1);
      end
      i_req0 = 0; i_req1 = 0;
`ifdef ALU_CTRL_RR_EN
      exp_grants = '{0, 1, 0, 1};
`else
      exp_grants = '{0, 0, 0, 0};
`endif
      check("arb_count", grants.size(), 32'd4);
      for (int i = 0; i < 4 && i < grants.size(); i++) begin
         $display("txn arb grant %0d -> requester %0d", i, grants[i]);
         check($sformatf("arb_grant%0d", i), grants[i], exp_grants[i]);
      end
      repeat (6) @(negedge clk);
      cmp_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got no summary, expected summary");
      $fatal(1, "timeout");
   end

endmodule
